// File: rtl/seven_segment_scan_driver_if.sv
// Display bus between the BCD/blink source and the 7-segment scan driver.
// master: drives enable, packed BCD digits and decimal points.
// slave:  the scan driver, which drives anodes, segments, DP, index and frame pulse.
interface seven_segment_scan_driver_if #(
    parameter int unsigned DECIMAL_DIGITS = 4
);
    localparam int unsigned INDEX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;

    logic                          i_Enable;
    logic [DECIMAL_DIGITS*4-1:0]   i_BCD_Num;
    logic [DECIMAL_DIGITS-1:0]     i_DP;
    logic [DECIMAL_DIGITS-1:0]     o_Anode;
    logic [6:0]                    o_Segment;
    logic                          o_DP;
    logic [INDEX_W-1:0]            o_Digit_Index;
    logic                          o_Frame_Done;

    modport master (
        output i_Enable,
        output i_BCD_Num,
        output i_DP,
        input  o_Anode,
        input  o_Segment,
        input  o_DP,
        input  o_Digit_Index,
        input  o_Frame_Done
    );

    modport slave (
        input  i_Enable,
        input  i_BCD_Num,
        input  i_DP,
        output o_Anode,
        output o_Segment,
        output o_DP,
        output o_Digit_Index,
        output o_Frame_Done
    );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed 7-segment scan driver.
// Each digit slot begins with BLANK_CLKS all-dark cycles (anti-ghosting) and then
// shows one digit with its anode pulled low. BCD/DP inputs are snapshotted once per
// frame so a frame never mixes old and new values. Blink code 4'hE decodes dark.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seven_segment_scan_driver #(
    parameter int unsigned DECIMAL_DIGITS = 4,
    parameter int unsigned CLKS_PER_DIGIT = 100000,
    parameter int unsigned BLANK_CLKS     = 1000
) (
    input logic                         i_Clk,
    input logic                         i_Rst_n,
    seven_segment_scan_driver_if.slave  bus
);
    localparam int unsigned INDEX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    localparam int unsigned SLOT_W  = $clog2(CLKS_PER_DIGIT);
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned NIB_W   = 4;

    localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_CLKS - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [INDEX_W-1:0] DIGIT_LAST = INDEX_W'(DECIMAL_DIGITS - 1);
    localparam logic [SEG_W-1:0]   SEG_OFF    = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q,  slot_d;
    logic [INDEX_W-1:0]  digit_q, digit_d;

    logic [NIB_W-1:0]           snap_nib [DECIMAL_DIGITS];
    logic [DECIMAL_DIGITS-1:0]  snap_dp;
    logic                       snap_take_c;

    logic [DECIMAL_DIGITS-1:0]  anode_d,  anode_q;
    logic [SEG_W-1:0]           seg_d,    seg_q;
    logic                       dp_d,     dp_q;
    logic                       fdone_d,  fdone_q;
    logic [INDEX_W-1:0]         index_q;
    logic                       digit_dark_c;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one nibble.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hF:    seg = 7'h3F;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    // Snapshot is taken on the first BLANK cycle of digit 0 (start of a frame).
    assign snap_take_c = (state_q == ST_BLANK) && (digit_q == '0) && (slot_q == '0);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [DECIMAL_DIGITS-1:0] lz_flag_c;
    logic [DECIMAL_DIGITS-1:0] lz_blank_q;

    // Flag zeros from the most significant digit down until the first non-zero nibble.
    always_comb begin
        logic run;
        lz_flag_c = '0;
        run       = 1'b1;
        for (int k = int'(DECIMAL_DIGITS) - 1; k >= 1; k--) begin
            if (run && (bus.i_BCD_Num[NIB_W*k +: NIB_W] == 4'h0)) begin
                lz_flag_c[k] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

    // Leading-zero flags travel with the frame snapshot.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            lz_blank_q <= '0;
        end else if (snap_take_c) begin
            lz_blank_q <= lz_flag_c;
        end
    end

    assign digit_dark_c = lz_blank_q[digit_q];
`else
    assign digit_dark_c = 1'b0;
`endif

    // Frame shadow of BCD digits and decimal points.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int k = 0; k < int'(DECIMAL_DIGITS); k++) begin
                snap_nib[k] <= '0;
            end
            snap_dp <= '0;
        end else if (snap_take_c) begin
            for (int k = 0; k < int'(DECIMAL_DIGITS); k++) begin
                snap_nib[k] <= bus.i_BCD_Num[NIB_W*k +: NIB_W];
            end
            snap_dp <= bus.i_DP;
        end
    end

    // Scan state, slot counter and digit index registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            digit_q <= digit_d;
        end
    end

    // Next-state sequencing and next values of the display outputs.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        digit_d = digit_q;
        anode_d = '1;
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
        fdone_d = 1'b0;

        if (!bus.i_Enable) begin
            state_d = ST_IDLE;
            slot_d  = '0;
            digit_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    slot_d  = '0;
                    digit_d = '0;
                end
                ST_BLANK: begin
                    slot_d = slot_q + SLOT_W'(1);
                    if (slot_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (slot_q == SLOT_LAST) begin
                        state_d = ST_BLANK;
                        slot_d  = '0;
                        digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + INDEX_W'(1);
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                    digit_d = '0;
                end
            endcase
        end

        if (state_q == ST_SHOW) begin
            anode_d[digit_q] = 1'b0;
            seg_d            = digit_dark_c ? SEG_OFF : seg_decode(snap_nib[digit_q]);
            dp_d             = ~snap_dp[digit_q];
            fdone_d          = (slot_q == SLOT_LAST) && (digit_q == DIGIT_LAST);
        end
    end

    // Output registers; async reset darkens the display immediately.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            anode_q <= '1;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            fdone_q <= 1'b0;
            index_q <= '0;
        end else begin
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fdone_q <= fdone_d;
            index_q <= digit_q;
        end
    end

    assign bus.o_Anode       = anode_q;
    assign bus.o_Segment     = seg_q;
    assign bus.o_DP          = dp_q;
    assign bus.o_Frame_Done  = fdone_q;
    assign bus.o_Digit_Index = index_q;

endmodule

// File: doc/seven_segment_scan_driver.md
Name: seven_segment_scan_driver

Overview:
- Display-end consumer of the packed BCD bus produced by the digit blinker and clock datapath.
- Time-multiplexes DECIMAL_DIGITS BCD nibbles onto one shared 7-segment and DP bus plus per-digit anodes.
- Decodes the blink code 4'b1110 as a dark digit.
- Inserts an all-off dead time before each digit to suppress ghosting.
- Sits between the blinker output and the board display pins.

Parameters:
- DECIMAL_DIGITS, 4: number of digits scanned. Nibble k is i_BCD_Num[4k+3:4k]; digit 0 is the rightmost.
- CLKS_PER_DIGIT, 100000: clocks per digit slot (1 ms at 100 MHz). Must be >= 2.
- BLANK_CLKS, 1000: dead-time clocks at the start of each slot. Must satisfy 1 <= BLANK_CLKS < CLKS_PER_DIGIT.

Ports:
- i_Clk  in  1  system clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_Enable  in  1  scan enable
- i_BCD_Num  in  DECIMAL_DIGITS*4  packed BCD digits (blink code 4'hE = blank)
- i_DP  in  DECIMAL_DIGITS  decimal point per digit, active-high
- o_Anode  out  DECIMAL_DIGITS  digit select, active-low
- o_Segment  out  7  {g,f,e,d,c,b,a}, active-low
- o_DP  out  1  decimal point, active-low
- o_Digit_Index  out  clog2(DECIMAL_DIGITS) (min 1)  digit currently in its slot
- o_Frame_Done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- **Reset** (async assert, sync release). All outputs are registered. Reset values: o_Anode all 1s, o_Segment 7'h7F, o_DP 1, o_Digit_Index 0, o_Frame_Done 0, FSM in IDLE, counters 0.
- **FSM states:** IDLE, BLANK, SHOW.
  - IDLE -> BLANK when i_Enable=1, starting slot of digit 0 with slot counter 0.
  - BLANK: slot counter 0..BLANK_CLKS-1; anodes all off; segments 7'h7F.
  - BLANK -> SHOW when slot counter = BLANK_CLKS-1.
  - SHOW: slot counter BLANK_CLKS..CLKS_PER_DIGIT-1; exactly one anode low (bit = digit index).
  - At slot counter = CLKS_PER_DIGIT-1, SHOW -> BLANK, counter resets to 0, digit index increments.
  - Digit index wraps from DECIMAL_DIGITS-1 to 0.
- **Output latency:** registered outputs lag the internal state by exactly 1 cycle.
- **Frame snapshot:** i_BCD_Num and i_DP are captured into a shadow register on the first BLANK cycle of digit 0. All decoding in that frame uses the snapshot, so there is no tearing mid-frame. An input change takes effect at the next frame start.
- **Decode** (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - A-D = 7F (blank), E = 7F (blink blank), F = 3F (dash, g only).
  - o_DP = ~snapshot DP[index] during SHOW; 1 otherwise.
- **o_Frame_Done:** asserted (registered) for the one cycle following the last SHOW cycle of digit DECIMAL_DIGITS-1.
- **Disable:** i_Enable=0 in any state -> IDLE next cycle. Registered outputs return to reset values one cycle later, and counters/index clear to 0. No frame-done pulse is generated for a truncated frame.
- **Re-enable:** always restarts at digit 0 BLANK with a fresh snapshot.
- **Reset mid-slot:** outputs go dark immediately (async).
- Anode low and segment data always change on the same edge. A BLANK cycle separates every anode transition.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- **Defined:** at snapshot time, each digit from DECIMAL_DIGITS-1 downward whose value is 0 is flagged blank (7'h7F) until the first non-zero nibble. Any value other than 0, including E and F, ends suppression. Digit 0 is never suppressed. Suppressed digits still get their slot and still show their DP.
- **Undefined:** all zeros are displayed and the flag logic is absent.

Test Plan:
All scenarios use DECIMAL_DIGITS=4, CLKS_PER_DIGIT=8, BLANK_CLKS=2.
- **Reset and dark state:** hold i_Rst_n=0, then release with i_Enable=0 -> o_Anode=4'hF, o_Segment=7'h7F, o_DP=1 indefinitely.
- **Basic scan:** i_Enable=1, i_BCD_Num=16'h1234.
  - Each slot: 2 cycles anodes F, then 6 cycles of one anode low.
  - Sequence: anode E/seg 19, D/30, B/24, 7/79.
  - o_Frame_Done pulses once per 32 cycles.
- **Blink code and dash:** i_BCD_Num=16'hF0E9, i_DP=4'b0010.
  - Digit 0 -> 10; digit 1 -> 7F with o_DP=0; digit 2 -> 40; digit 3 -> 3F.
- **Snapshot:** change i_BCD_Num from 16'h1111 to 16'h2222 during digit 2's SHOW -> digits 2 and 3 still show 79; next frame shows 24.
- **Disable/reset mid-operation:**
  - i_Enable=0 during digit 1 SHOW -> one cycle later all anodes F, no frame-done pulse; re-enable restarts at digit 0 BLANK.
  - Async i_Rst_n=0 mid-slot -> outputs dark without waiting for a clock edge.
- **SEG_LEADING_ZERO_BLANK_EN:** i_BCD_Num=16'h0005 -> digits 3..1 show 7F, digit 0 shows 12. 16'h0000 -> only digit 0 shows 40. 16'h0E05 -> digit 3 blank, digit 2 shows 7F (blink), digit 1 shows 40.
